// File: rtl/alu_status_stage_pkg.sv
// Shared types and constants for the ALU status stage.
// Flag layout, opcode encodings and the buffered entry record.
package alu_status_stage_pkg;

  localparam int FLAG_V = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  localparam logic [1:0] OP_LOGIC = 2'b00;
  localparam logic [1:0] OP_ADD   = 2'b01;
  localparam logic [1:0] OP_SUB   = 2'b10;
  localparam logic [1:0] OP_ADC   = 2'b11;

  typedef struct packed {
    logic [3:0] y;
    logic [3:0] flags;
  } entry_t;

  // Logic ops carry no meaningful carry or overflow.
  function automatic logic [3:0] calcFlags(
    input logic [1:0] op,
    input logic [4:0] res,
    input logic       ovfIn
  );
    logic [3:0] f;
    f         = '0;
    f[FLAG_Z] = (res[3:0] == 4'd0);
    f[FLAG_N] = res[3];
    f[FLAG_C] = (op != OP_LOGIC) & res[4];
    f[FLAG_V] = (op != OP_LOGIC) & ovfIn;
    return f;
  endfunction

endpackage

// File: rtl/alu_status_stage_status_fifo.sv
// FIFO storage for status entries.
// Power-of-two depth, so pointers wrap by natural overflow.
module status_fifo
  import alu_status_stage_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  logic   pop,
  input  entry_t wrData,
  output entry_t rdData,
  output logic   full,
  output logic   empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  entry_t        mem [DEPTH];
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;
  logic [CW-1:0] count;
  logic          doPush;
  logic          doPop;

  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign doPush = push & ~full;
  assign doPop  = pop & ~empty;
  assign rdData = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= wrData;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop) rdPtr <= rdPtr + 1'b1;
      if (doPush && !doPop) count <= count + 1'b1;
      else if (doPop && !doPush) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/alu_status_stage.sv
// ALU status stage: buffers results with flags,
// tracks sticky overflow and a saturating overflow count.
module alu_status_stage
  import alu_status_stage_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       opCode,
  input  logic [4:0]       Y,
  input  logic             ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_Y,
  output logic [3:0]       out_flags,
  output logic             sticky_ovf,
  output logic [CNT_W-1:0] ovf_count,
  input  logic             clr_status
);

  entry_t wrEntry;
  entry_t rdEntry;
  logic   full;
  logic   empty;
  logic   live;
  logic   accept;
  logic   pop;
  logic   ovfBeat;

  assign wrEntry.y     = Y[3:0];
  assign wrEntry.flags = calcFlags(opCode, Y, ovf);

  // live holds in_ready low for the first edge after reset.
  assign in_ready  = live & ~full;
  assign out_valid = ~empty;
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign ovfBeat   = accept & wrEntry.flags[FLAG_V];

  assign out_Y     = out_valid ? rdEntry.y : 4'd0;
  assign out_flags = out_valid ? rdEntry.flags : 4'd0;

  status_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept),
    .pop   (pop),
    .wrData(wrEntry),
    .rdData(rdEntry),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) live <= 1'b0;
    else        live <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_ovf <= 1'b0;
      ovf_count  <= '0;
    end else begin
      if (ovfBeat)         sticky_ovf <= 1'b1;
      else if (clr_status) sticky_ovf <= 1'b0;
      if (clr_status)
        ovf_count <= CNT_W'(ovfBeat);
      else if (ovfBeat && ovf_count != '1)
        ovf_count <= ovf_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_status_stage.sv
// Self-checking bench for alu_status_stage.
// Queue-based reference model, randomized stimulus.
module tb_alu_status_stage;

  localparam int DEPTH = 2;
  localparam int CNT_W = 2;
  localparam int CMAX  = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       opCode = 2'b00;
  logic [4:0]       Y = 5'd0;
  logic             ovf = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [3:0]       out_Y;
  logic [3:0]       out_flags;
  logic             sticky_ovf;
  logic [CNT_W-1:0] ovf_count;
  logic             clr_status = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [7:0] mq[$];
  bit         mLive = 0;
  bit         mSticky = 0;
  int         mCnt = 0;

  alu_status_stage #(
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opCode    (opCode),
    .Y         (Y),
    .ovf       (ovf),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_Y     (out_Y),
    .out_flags (out_flags),
    .sticky_ovf(sticky_ovf),
    .ovf_count (ovf_count),
    .clr_status(clr_status)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] refFlags(
    input logic [1:0] op, input int y, input bit ov
  );
    int lo;
    bit arith;
    lo    = y % 16;
    arith = (op != 2'b00);
    return {arith && ov, arith && (y >= 16), lo >= 8, lo == 0};
  endfunction

  function automatic bit expReady();
    return mLive && (mq.size() < DEPTH);
  endfunction

  function automatic bit expValid();
    return mq.size() > 0;
  endfunction

  function automatic logic [3:0] expY();
    logic [7:0] e;
    if (mq.size() == 0) return 4'h0;
    e = mq[0];
    return e[7:4];
  endfunction

  function automatic logic [3:0] expF();
    logic [7:0] e;
    if (mq.size() == 0) return 4'h0;
    e = mq[0];
    return e[3:0];
  endfunction

  function automatic void mReset();
    mq.delete();
    mLive   = 0;
    mSticky = 0;
    mCnt    = 0;
  endfunction

  task automatic drive(
    input bit iv, input logic [1:0] op, input logic [4:0] y,
    input bit ov, input bit ordy, input bit clr
  );
    bit acc;
    bit pp;
    bit v;
    logic [3:0] lo;
    in_valid   = iv;
    opCode     = op;
    Y          = y;
    ovf        = ov;
    out_ready  = ordy;
    clr_status = clr;
    acc = iv && expReady();
    pp  = ordy && expValid();
    v   = acc && (op != 2'b00) && ov;
    lo  = y[3:0];
    @(posedge clk);
    #1;
    if (pp) void'(mq.pop_front());
    if (acc) mq.push_back({lo, refFlags(op, int'(y), ov)});
    if (rst_n) mLive = 1;
    if (clr) mCnt = v ? 1 : 0;
    else if (v && mCnt < CMAX) mCnt++;
    if (v) mSticky = 1;
    else if (clr) mSticky = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    mReset();
    checks++;
    if ({in_ready, out_valid, out_Y, out_flags, sticky_ovf, ovf_count} !== '0) begin
      errors++;
      $display("FAIL reset_state actual=%b required=0",
        {in_ready, out_valid, out_Y, out_flags, sticky_ovf, ovf_count});
    end
    rst_n = 1'b1;
    drive(1, 2'b01, 5'h03, 0, 1, 0);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_rise actual=%b required=1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL no_accept_first_edge actual=%b required=0", out_valid);
    end
  endtask

  task automatic test_basic();
    drive(1, 2'b01, 5'b10000, 1, 1, 0);
    checks++;
    if ({out_valid, out_Y, out_flags} !== 9'b1_0000_1101) begin
      errors++;
      $display("FAIL basic_out actual=%b required=%b",
        {out_valid, out_Y, out_flags}, 9'b1_0000_1101);
    end
    drive(0, 2'b00, 5'd0, 0, 1, 0);
    checks++;
    if ({sticky_ovf, ovf_count} !== 3'b1_01) begin
      errors++;
      $display("FAIL basic_status actual=%b required=101",
        {sticky_ovf, ovf_count});
    end
    checks++;
    if ({out_valid, out_Y, out_flags} !== 9'd0) begin
      errors++;
      $display("FAIL empty_zero actual=%b required=0",
        {out_valid, out_Y, out_flags});
    end
    drive(0, 2'b00, 5'd0, 0, 1, 1);
    checks++;
    if ({sticky_ovf, ovf_count} !== 3'b0) begin
      errors++;
      $display("FAIL clear actual=%b required=000", {sticky_ovf, ovf_count});
    end
  endtask

  task automatic test_backpressure();
    drive(1, 2'b01, 5'h03, 0, 0, 0);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_ready1 actual=%b required=1", in_ready);
    end
    drive(1, 2'b10, 5'h1A, 0, 0, 0);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_full actual=%b required=0", in_ready);
    end
    drive(1, 2'b11, 5'h08, 1, 0, 0);
    checks++;
    if ({in_ready, out_Y} !== 5'b0_0011) begin
      errors++;
      $display("FAIL bp_hold actual=%b required=00011", {in_ready, out_Y});
    end
    drive(1, 2'b11, 5'h08, 1, 1, 0);
    checks++;
    if ({in_ready, out_Y} !== 5'b1_1010) begin
      errors++;
      $display("FAIL bp_pop1 actual=%b required=11010", {in_ready, out_Y});
    end
    drive(1, 2'b11, 5'h08, 1, 1, 0);
    checks++;
    if ({out_Y, out_flags} !== 8'b1000_1010) begin
      errors++;
      $display("FAIL bp_third actual=%b required=10001010", {out_Y, out_flags});
    end
    drive(0, 2'b00, 5'd0, 0, 1, 0);
    checks++;
    if (out_valid !== 1'b0 || ovf_count !== CNT_W'(mCnt)) begin
      errors++;
      $display("FAIL bp_drain actual=%b/%0d required=0/%0d",
        out_valid, ovf_count, mCnt);
    end
  endtask

  task automatic test_logic_op();
    logic [CNT_W-1:0] c0;
    drive(0, 2'b00, 5'd0, 0, 1, 1);
    c0 = ovf_count;
    drive(1, 2'b00, 5'b11000, 1, 1, 0);
    checks++;
    if ({out_Y, out_flags} !== 8'b1000_0010) begin
      errors++;
      $display("FAIL logic_flags actual=%b required=10000010",
        {out_Y, out_flags});
    end
    drive(0, 2'b00, 5'd0, 0, 1, 0);
    checks++;
    if (sticky_ovf !== 1'b0 || ovf_count !== c0) begin
      errors++;
      $display("FAIL logic_status actual=%b/%0d required=0/%0d",
        sticky_ovf, ovf_count, c0);
    end
  endtask

  task automatic test_saturation();
    int expc[4] = '{1, 2, 3, 3};
    for (int i = 0; i < 4; i++) begin
      drive(1, 2'b01, 5'($urandom), 1, 1, 0);
      checks++;
      if (ovf_count !== CNT_W'(expc[i])) begin
        errors++;
        $display("FAIL sat_%0d actual=%0d required=%0d",
          i, ovf_count, expc[i]);
      end
    end
    drive(1, 2'b10, 5'($urandom), 1, 1, 1);
    checks++;
    if ({sticky_ovf, ovf_count} !== 3'b1_01) begin
      errors++;
      $display("FAIL clr_with_ovf actual=%b required=101",
        {sticky_ovf, ovf_count});
    end
    drive(0, 2'b00, 5'd0, 0, 1, 0);
  endtask

  task automatic test_back_to_back();
    logic [4:0] sent[16];
    for (int i = 0; i < 16; i++) begin
      sent[i] = 5'($urandom);
      drive(1, 2'($urandom), sent[i], 1'($urandom), 1, 0);
      checks++;
      if ({in_ready, out_valid, out_Y} !== {2'b11, sent[i][3:0]}) begin
        errors++;
        $display("FAIL b2b_%0d actual=%b required=%b",
          i, {in_ready, out_valid, out_Y}, {2'b11, sent[i][3:0]});
      end
      checks++;
      if (out_flags !== expF()) begin
        errors++;
        $display("FAIL b2b_flags_%0d actual=%b required=%b",
          i, out_flags, expF());
      end
    end
    drive(0, 2'b00, 5'd0, 0, 1, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      drive(($urandom % 4) != 0, 2'($urandom), 5'($urandom),
        1'($urandom), ($urandom % 3) != 0, ($urandom % 16) == 0);
      checks++;
      if ({in_ready, out_valid} !== {expReady(), expValid()}) begin
        errors++;
        $display("FAIL rnd_hs cyc=%0d actual=%b required=%b",
          i, {in_ready, out_valid}, {expReady(), expValid()});
      end
      checks++;
      if ({out_Y, out_flags} !== {expY(), expF()}) begin
        errors++;
        $display("FAIL rnd_data cyc=%0d actual=%h required=%h",
          i, {out_Y, out_flags}, {expY(), expF()});
      end
      checks++;
      if (sticky_ovf !== mSticky || ovf_count !== CNT_W'(mCnt)) begin
        errors++;
        $display("FAIL rnd_status cyc=%0d actual=%b/%0d required=%b/%0d",
          i, sticky_ovf, ovf_count, mSticky, mCnt);
      end
    end
  endtask

  task automatic test_async_reset();
    drive(0, 2'b00, 5'd0, 0, 1, 0);
    drive(0, 2'b00, 5'd0, 0, 1, 0);
    drive(1, 2'b01, 5'h1F, 1, 0, 0);
    drive(1, 2'b01, 5'h17, 1, 0, 0);
    checks++;
    if ({out_valid, in_ready} !== 2'b10 || ovf_count === '0) begin
      errors++;
      $display("FAIL ar_pre actual=%b/%0d required=10/nonzero",
        {out_valid, in_ready}, ovf_count);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, sticky_ovf, ovf_count, out_Y} !== '0) begin
      errors++;
      $display("FAIL ar_async actual=%b required=0",
        {out_valid, in_ready, sticky_ovf, ovf_count, out_Y});
    end
    mReset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(0, 2'b00, 5'd0, 0, 1, 0);
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL ar_no_stale actual=%b required=01",
        {out_valid, in_ready});
    end
    drive(1, 2'b10, 5'h05, 0, 0, 0);
    checks++;
    if ({out_valid, out_Y, out_flags} !== {1'b1, 4'h5, 4'b0000}) begin
      errors++;
      $display("FAIL ar_resume actual=%b required=%b",
        {out_valid, out_Y, out_flags}, {1'b1, 4'h5, 4'b0000});
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_logic_op();
    test_saturation();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
